// File: rtl/temp_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : temp_sampler
//  Description : Periodically triggers an external 8-bit temperature
//                converter, validates the returned sample, smooths good
//                samples with a 4-entry moving average and flags converter
//                faults (timeout or open-circuit code 8'hFF).
//  Revision    : 1.0 - initial release
// ============================================================================
module temp_sampler #(
    parameter int unsigned PERIOD  = 1000,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [7:0]  T_INIT  = 8'd25
) (
    input  logic       clk,
    input  logic       rst,
    output logic       conv_start,
    input  logic       conv_done,
    input  logic [7:0] adc_data,
    output logic [7:0] t,
    output logic       t_valid,
    output logic       sensor_err
);

    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(PERIOD - 1);
    localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT - 1);
    localparam logic [7:0]       c_open_ckt = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_ACC   = 2'd3
    } state_t;

    state_t           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [TMR_W-1:0] timer_q,      timer_d;
    logic [7:0]       sample_q,     sample_d;
    logic             primed_q,     primed_d;
    logic [7:0]       buf_q [4];
    logic [7:0]       buf_d [4];
    logic [1:0]       idx_q,        idx_d;
    logic [9:0]       sum_q,        sum_d;
    logic [7:0]       t_q,          t_d;
    logic             t_valid_q,    t_valid_d;
    logic             err_q,        err_d;
    logic             conv_start_q, conv_start_d;

    logic             w_tick;
    logic [9:0]       w_sum_new;

    // Next-state logic: free-running period counter, conversion FSM and averager
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        sample_d     = sample_q;
        primed_d     = primed_q;
        buf_d        = buf_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        t_d          = t_q;
        err_d        = err_q;
        t_valid_d    = 1'b0;
        conv_start_d = 1'b0;

        // The counter never stops; a tick outside IDLE is simply not acted on
        w_tick = (cnt_q == c_cnt_last);
        cnt_d  = w_tick ? '0 : cnt_q + 1'b1;

        // A fresh (unprimed) average starts from four copies of the sample;
        // afterwards the oldest ring entry is swapped for the new sample
        if (primed_q) begin
            w_sum_new = sum_q - {2'b00, buf_q[idx_q]} + {2'b00, sample_q};
        end else begin
            w_sum_new = {sample_q, 2'b00};
        end

        case (state_q)
            S_IDLE: begin
                if (w_tick) begin
                    state_d      = S_START;
                    conv_start_d = 1'b1;
                end
            end
            S_START: begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                // Done is tested before the timeout so a result on the last
                // allowed cycle is still accepted
                if (conv_done) begin
                    sample_d = adc_data;
                    if (adc_data == c_open_ckt) begin
                        err_d    = 1'b1;
                        primed_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        state_d  = S_ACC;
                    end
                end else if (timer_q == c_tmr_last) begin
                    err_d    = 1'b1;
                    primed_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_ACC: begin
                state_d   = S_IDLE;
                err_d     = 1'b0;
                t_valid_d = 1'b1;
                sum_d     = w_sum_new;
                t_d       = w_sum_new[9:2];
                if (primed_q) begin
                    buf_d[idx_q] = sample_q;
                    idx_d        = idx_q + 2'd1;
                end else begin
                    buf_d    = '{sample_q, sample_q, sample_q, sample_q};
                    primed_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset to the power-up condition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            timer_q      <= '0;
            sample_q     <= '0;
            primed_q     <= 1'b0;
            buf_q        <= '{default: '0};
            idx_q        <= '0;
            sum_q        <= '0;
            t_q          <= T_INIT;
            t_valid_q    <= 1'b0;
            err_q        <= 1'b0;
            conv_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            sample_q     <= sample_d;
            primed_q     <= primed_d;
            buf_q        <= buf_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            t_q          <= t_d;
            t_valid_q    <= t_valid_d;
            err_q        <= err_d;
            conv_start_q <= conv_start_d;
        end
    end

    assign conv_start = conv_start_q;
    assign t          = t_q;
    assign t_valid    = t_valid_q;
    assign sensor_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_temp_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_temp_sampler
//  Description : Self-checking bench for temp_sampler (PERIOD=16, TIMEOUT=8).
//                A behavioural model keeps the last four good samples in a
//                queue and derives the expected temperature arithmetically.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_temp_sampler;

    localparam int unsigned PERIOD  = 16;
    localparam int unsigned TIMEOUT = 8;
    localparam logic [7:0]  T_INIT  = 8'd25;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       conv_done = 1'b0;
    logic [7:0] adc_data = 8'd0;
    logic       conv_start;
    logic [7:0] t;
    logic       t_valid;
    logic       sensor_err;

    temp_sampler #(
        .PERIOD  (PERIOD),
        .TIMEOUT (TIMEOUT),
        .T_INIT  (T_INIT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .conv_start (conv_start),
        .conv_done  (conv_done),
        .adc_data   (adc_data),
        .t          (t),
        .t_valid    (t_valid),
        .sensor_err (sensor_err)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release (matches the design's period count)
    int cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Observed t_valid pulses over the whole run
    int tv_seen = 0;
    always @(negedge clk) begin
        if (t_valid) tv_seen <= tv_seen + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int m_win[$];
    bit m_primed = 1'b0;
    int m_t      = 25;
    bit m_err    = 1'b0;
    int m_tv     = 0;
    int exp_start = 16;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_good(input int s);
        int sum;
        if (!m_primed) begin
            m_win = '{s, s, s, s};
            m_primed = 1'b1;
        end else begin
            m_win.push_back(s);
            void'(m_win.pop_front());
        end
        sum = 0;
        foreach (m_win[i]) sum += m_win[i];
        m_t   = sum / 4;
        m_err = 1'b0;
        m_tv++;
    endtask

    task automatic model_fault();
        m_err    = 1'b1;
        m_primed = 1'b0;
    endtask

    task automatic model_reset();
        m_win.delete();
        m_primed  = 1'b0;
        m_t       = 25;
        m_err     = 1'b0;
        exp_start = 16;
    endtask

    // Advance to the negedge of the START cycle and check its timing
    task automatic wait_start();
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (conv_start) seen = 1'b1;
        end
        check_eq("start_seen", int'(seen), 1);
        check_eq("start_cycle", cyc, exp_start);
        exp_start += 16;
    endtask

    // mode 0: good sample, 1: timeout, 2: open-circuit code.
    // j is the WAIT cycle (0-based) carrying conv_done.
    task automatic run_conv(input int mode, input int j, input logic [7:0] val,
                            input bit start_poke);
        wait_start();
        if (start_poke) begin
            conv_done = 1'b1;
            adc_data  = 8'($urandom);
        end
        @(negedge clk);
        conv_done = 1'b0;
        check_eq("start_one_cycle", int'(conv_start), 0);
        if (mode == 1) begin
            repeat (7) @(negedge clk);
            check_eq("err_before_timeout", int'(sensor_err), int'(m_err));
            @(negedge clk);
            model_fault();
            check_eq("timeout_err", int'(sensor_err), 1);
            check_eq("timeout_t_held", int'(t), m_t);
            check_eq("timeout_no_valid", int'(t_valid), 0);
        end else begin
            repeat (j) @(negedge clk);
            conv_done = 1'b1;
            adc_data  = val;
            @(negedge clk);
            conv_done = 1'b0;
            adc_data  = 8'($urandom);
            check_eq("valid_not_early", int'(t_valid), 0);
            if (mode == 2) begin
                model_fault();
                check_eq("ff_err", int'(sensor_err), 1);
                check_eq("ff_t_held", int'(t), m_t);
            end else begin
                model_good(int'(val));
                @(negedge clk);
                check_eq("t_value", int'(t), m_t);
                check_eq("t_valid_pulse", int'(t_valid), 1);
                check_eq("err_cleared", int'(sensor_err), 0);
                @(negedge clk);
                check_eq("t_valid_one_cycle", int'(t_valid), 0);
            end
        end
    endtask

    initial begin
        int mode, r;

        // Power-up reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_conv_start", int'(conv_start), 0);
        check_eq("rst_t", int'(t), 25);
        check_eq("rst_t_valid", int'(t_valid), 0);
        check_eq("rst_err", int'(sensor_err), 0);
        rst = 1'b0;

        // First conversion with a done poke in START, then averaging
        run_conv(0, 2, 8'd40, 1'b1);
        check_eq("prime_40", int'(t), 40);
        run_conv(0, 1, 8'd20, 1'b0);
        check_eq("avg_35", int'(t), 35);
        run_conv(0, 4, 8'd20, 1'b0);
        check_eq("avg_30", int'(t), 30);
        run_conv(0, 0, 8'd21, 1'b1);
        check_eq("avg_25_trunc", int'(t), 25);
        for (int i = 0; i < 4; i++) run_conv(0, i, 8'd50, 1'b0);
        check_eq("avg_50", int'(t), 50);

        // Faults and re-priming
        run_conv(1, 0, 8'd0, 1'b0);
        run_conv(0, 3, 8'd30, 1'b0);
        check_eq("reprime_30", int'(t), 30);
        run_conv(2, 2, 8'hFF, 1'b0);
        run_conv(0, 7, 8'd60, 1'b0);
        check_eq("last_wait_cycle_60", int'(t), 60);
        run_conv(1, 0, 8'd0, 1'b0);

        // Reset during WAIT
        wait_start();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_conv_start", int'(conv_start), 0);
        check_eq("mid_rst_t", int'(t), 25);
        check_eq("mid_rst_t_valid", int'(t_valid), 0);
        check_eq("mid_rst_err", int'(sensor_err), 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        conv_done = 1'b1;
        adc_data  = 8'd99;
        @(negedge clk);
        conv_done = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("post_rst_done_ignored_t", int'(t), 25);
        check_eq("post_rst_done_ignored_err", int'(sensor_err), 0);

        // Randomized conversions
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            mode = (r < 8) ? 0 : (r == 8) ? 1 : 2;
            run_conv(mode, int'($urandom_range(0, 7)),
                     (mode == 2) ? 8'hFF : 8'($urandom_range(0, 254)),
                     1'($urandom_range(0, 1)));
            check_eq("rand_t", int'(t), m_t);
            check_eq("rand_err", int'(sensor_err), int'(m_err));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                conv_done = 1'b1;
                adc_data  = 8'($urandom);
                @(negedge clk);
                conv_done = 1'b0;
                check_eq("idle_done_ignored", int'(t), m_t);
            end
        end

        @(posedge clk);
        @(posedge clk);
        check_eq("t_valid_count", tv_seen, m_tv);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
